ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It is the outbound counterpart of the keyboard receiver and sends command bytes to the keyboard, e.g. 0xED plus an LED mask, or 0xFF reset.
- Drives the shared PS2_CLK/PS2_DATA lines through open-drain enables; the top level builds the tri-state pads.
- Reports transfer completion or failure to the issuing logic through a valid/ready handshake and status pulses.

---
 rtl/ps2_host_tx.sv | 194 +++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain clock/data enables.
// Optional device-clock watchdog is enabled by defining PS2_TX_TIMEOUT_EN.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int SETUP_CYCLES   = 200,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic       busy,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int PH_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int FL_W   = $clog2(FILTER_LEN + 1);

  if (INHIBIT_CYCLES < 1 || SETUP_CYCLES < 1 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("ps2_host_tx: all cycle parameters must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_INHIBIT   = 3'd1,
    S_REQ       = 3'd2,
    S_XFER      = 3'd3,
    S_WAIT_IDLE = 3'd4,
    S_ERR       = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic              clk_s1_q, clk_s2_q;
  logic              dat_s1_q, dat_s2_q;
  logic              filt_clk_q, filt_clk_d;
  logic [FL_W-1:0]   filt_cnt_q, filt_cnt_d;
  logic              fall_q, fall_d;
  logic [PH_W-1:0]   ph_cnt_q, ph_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [9:0]        shift_q, shift_d;
  logic              data_bit_q, data_bit_d;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
`endif

  // Glitch filter: accept a new clock level only after it persists FILTER_LEN cycles.
  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FL_W'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FL_W'(1);
      end
    end
    fall_d = filt_clk_q & ~filt_clk_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      filt_clk_q <= 1'b1;
      filt_cnt_q <= '0;
      fall_q     <= 1'b0;
      ph_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      data_bit_q <= 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      clk_s1_q   <= ps2_clk_in;
      clk_s2_q   <= clk_s1_q;
      dat_s1_q   <= ps2_data_in;
      dat_s2_q   <= dat_s1_q;
      filt_clk_q <= filt_clk_d;
      filt_cnt_q <= filt_cnt_d;
      fall_q     <= fall_d;
      ph_cnt_q   <= ph_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      data_bit_q <= data_bit_d;
`ifdef PS2_TX_TIMEOUT_EN
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    ph_cnt_d   = ph_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    data_bit_d = data_bit_q;
`ifdef PS2_TX_TIMEOUT_EN
    to_cnt_d   = to_cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          shift_d  = {1'b1, ~^tx_data, tx_data};
          ph_cnt_d = '0;
          state_d  = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (ph_cnt_q == PH_W'(INHIBIT_CYCLES - 1)) begin
          ph_cnt_d = '0;
          state_d  = S_REQ;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_REQ: begin
        if (ph_cnt_q == PH_W'(SETUP_CYCLES - 1)) begin
          ph_cnt_d   = '0;
          bit_cnt_d  = '0;
          data_bit_d = 1'b1;  // keep the start bit on the line until the first device clock
`ifdef PS2_TX_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
          state_d    = S_XFER;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end
      S_XFER: begin
        if (fall_q) begin
          if (bit_cnt_q == 4'd10) begin
            data_bit_d = 1'b0;
            state_d    = dat_s2_q ? S_ERR : S_WAIT_IDLE;
          end else begin
            data_bit_d = ~shift_q[0];
            shift_d    = {1'b1, shift_q[9:1]};
            bit_cnt_d  = bit_cnt_q + 4'd1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (filt_clk_q && dat_s2_q) begin
          state_d = S_IDLE;
        end
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

`ifdef PS2_TX_TIMEOUT_EN
    // A legitimate completion in the same cycle wins over the watchdog.
    if (state_q == S_XFER || state_q == S_WAIT_IDLE) begin
      if (fall_q) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
        if (state_d == state_q) begin
          state_d = S_ERR;
        end
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
`endif
  end

  always_comb begin
    tx_ready    = (state_q == S_IDLE);
    busy        = ~tx_ready;
    ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    ps2_data_oe = (state_q == S_REQ) || ((state_q == S_XFER) && data_bit_q);
    tx_done     = (state_q == S_WAIT_IDLE) && filt_clk_q && dat_s2_q;
    tx_err      = (state_q == S_ERR);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx: device model on the open-drain lines,
// vector table plus random bytes against a frame-level reference.
module tb_ps2_host_tx;

  localparam int INH  = 20;
  localparam int SET  = 4;
  localparam int FLT  = 2;
  localparam int TOUT = 500;
  localparam int HALF = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err, busy;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       glitch = 1'b0;
  logic       clk_line, data_line, ps2_clk_in, ps2_data_in;

  assign clk_line    = ~ps2_clk_oe & dev_clk;
  assign data_line   = ~ps2_data_oe & dev_data;
  assign ps2_clk_in  = clk_line & ~glitch;
  assign ps2_data_in = data_line;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .FILTER_LEN    (FLT),
    .TIMEOUT_CYCLES(TOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_err     (tx_err),
    .busy       (busy),
    .ps2_clk_in (ps2_clk_in),
    .ps2_data_in(ps2_data_in),
    .ps2_clk_oe (ps2_clk_oe),
    .ps2_data_oe(ps2_data_oe)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference frame as the device sees it: start, data LSB first, odd parity, stop.
  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] f;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = d[i];
    f[9]  = ($countones(d) % 2) == 0;
    f[10] = 1'b1;
    return f;
  endfunction

  // Line monitor
  int cyc = 0;
  int n_done = 0, n_err = 0, n_req = 0;
  int clk_rise_cyc = 0, clk_run = -1, data_off = -1;
  logic clk_oe_prev = 1'b0, data_oe_prev = 1'b0, err_prev = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_done) n_done++;
      if (tx_err) n_err++;
      if (tx_done && tx_err) chk("done_err_same_cycle", 1, 0);
      if (tx_done) chk("done_lines_idle", {30'd0, ps2_clk_in, ps2_data_in}, 3);
      if (err_prev) chk("ready_after_err", tx_ready, 1);
      if (ps2_clk_oe && !clk_oe_prev) begin
        clk_rise_cyc = cyc;
        n_req++;
      end
      if (!ps2_clk_oe && clk_oe_prev) clk_run = cyc - clk_rise_cyc;
      if (ps2_clk_oe && ps2_data_oe && !data_oe_prev) data_off = cyc - clk_rise_cyc;
      err_prev     = tx_err;
      clk_oe_prev  = ps2_clk_oe;
      data_oe_prev = ps2_data_oe;
    end
  end

  task automatic clear_mon();
    n_done = 0; n_err = 0; n_req = 0; clk_run = -1; data_off = -1;
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock 11 pulses, ACK/NACK on the 11th.
  task automatic dev_frame(input bit ack, input int glitch_at, input bit poke,
                           input int abort_at, output logic [10:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    if (!ps2_clk_oe) begin chk("request_seen", 0, 1); return; end
    t = 0;
    while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    if (ps2_clk_oe) begin chk("clock_released", 1, 0); return; end
    bits[0] = data_line;
    repeat (10) @(negedge clk);
    for (int i = 0; i <= 10; i++) begin
      if (i == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == abort_at) begin
        chk("pre_rst_data_oe", ps2_data_oe, 1);
        rst = 1'b1;
        #1;
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        dev_clk = 1'b1;
        return;
      end
      if (i < 10) bits[i+1] = data_line;
      dev_clk = 1'b1;
      if (poke && i == glitch_at) begin
        tx_data  = 8'h55;
        tx_valid = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      tx_valid = 1'b0;
      if (i == glitch_at) begin
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        repeat (HALF) @(negedge clk);
      end
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_ready(input string name);
    int t = 0;
    while (!tx_ready && t < 300) begin @(negedge clk); t++; end
    if (!tx_ready) chk(name, 0, 1);
  endtask

  task automatic run_xfer(input logic [7:0] d, input bit ack, input int glitch_at,
                          input bit poke, input bit exp_done, input bit exp_err);
    logic [10:0] bits;
    clear_mon();
    send(d);
    dev_frame(ack, glitch_at, poke, -1, bits);
    wait_ready("ready_timeout");
    repeat (40) @(negedge clk);
    chk($sformatf("frame_%02h", d), int'(bits), int'(frame_of(d)));
    chk($sformatf("done_%02h", d), n_done, int'(exp_done));
    chk($sformatf("err_%02h", d), n_err, int'(exp_err));
    chk($sformatf("requests_%02h", d), n_req, 1);
    chk($sformatf("clk_oe_len_%02h", d), clk_run, INH + SET);
    chk($sformatf("data_oe_off_%02h", d), data_off, INH);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         glitch_at;
    bit         poke;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [10:0] bits;
    int t;
    vecs[0] = '{8'hED, 1'b1, -1, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, -1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{8'hA5, 1'b1,  3, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{8'hF4, 1'b1, -1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h3C, 1'b0,  6, 1'b0, 1'b0, 1'b1};

    // Reset behaviour
    clear_mon();
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", ps2_clk_oe, 0);
    chk("rst_data_oe", ps2_data_oe, 0);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_ready", tx_ready, 1);
    chk("idle_clk_oe", ps2_clk_oe, 0);
    chk("idle_pulses", n_done + n_err, 0);

    foreach (vecs[k])
      run_xfer(vecs[k].data, vecs[k].ack, vecs[k].glitch_at, vecs[k].poke,
               vecs[k].exp_done, vecs[k].exp_err);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] d;
      bit a;
      d = 8'($urandom_range(0, 255));
      a = ($urandom_range(0, 3) != 0);
      run_xfer(d, a, -1, 1'b0, a, !a);
    end

    // Device never clocks
    clear_mon();
    send(8'hFF);
    t = 0;
    while (!ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
    t = 0;
    while (ps2_clk_oe && t < 100) begin @(negedge clk); t++; end
`ifdef PS2_TX_TIMEOUT_EN
    t = 0;
    while (!tx_err && t < 2 * TOUT) begin @(negedge clk); t++; end
    chk("timeout_cycles", t, TOUT);
    chk("timeout_clk_oe", ps2_clk_oe, 0);
    chk("timeout_data_oe", ps2_data_oe, 0);
    wait_ready("timeout_ready");
    repeat (5) @(negedge clk);
    chk("timeout_err_count", n_err, 1);
    chk("timeout_done_count", n_done, 0);
`else
    repeat (3 * TOUT) @(negedge clk);
    chk("hang_busy", busy, 1);
    chk("hang_err_count", n_err, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("hang_recover_ready", tx_ready, 1);
`endif

    // Reset in the middle of bit 4
    clear_mon();
    send(8'hED);
    dev_frame(1'b1, -1, 1'b0, 4, bits);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_done", n_done, 0);
    chk("abort_err", n_err, 0);
    chk("abort_ready", tx_ready, 1);
    run_xfer(8'hF4, 1'b1, -1, 1'b0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

endmodule
